// File: rtl/lenet_pkg.sv
// ----------------------------------------------------------------------------
// lenet_pkg
// Shared types and constants for the LeNet digit post-processing blocks.
//   NUM_CLASSES  : number of digit classes produced by the classifier (0..9)
//   DIGIT_W      : width of a digit code
//   digit_t      : digit code type
//   vote_state_t : state encoding of the digit_vote controller
//   digit_ok()   : true when a digit code names a real class
// ----------------------------------------------------------------------------
package lenet_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int DIGIT_W     = 4;
    localparam int SCAN_LAST   = NUM_CLASSES - 1;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        UPDATE  = 2'd1,
        SCAN    = 2'd2,
        PUBLISH = 2'd3
    } vote_state_t;

    // Codes 10..15 are not classes and must never enter the vote window.
    function automatic logic digit_ok(input digit_t d);
        return (d < digit_t'(NUM_CLASSES));
    endfunction

endpackage

// File: rtl/digit_vote_hist.sv
// ----------------------------------------------------------------------------
// digit_vote_hist
// Per-class occurrence histogram of the vote window plus a sequential argmax.
//   clk24, rst_n      : clock, asynchronous active-low reset
//   clear_i           : synchronous flush of all bins and scan result
//   push_i            : one window update this cycle
//   push_digit_i      : digit entering the window
//   evict_i           : window is full, evict_digit_i leaves it this cycle
//   evict_digit_i     : digit leaving the window
//   scan_en_i         : examine bin scan_idx_i this cycle
//   scan_idx_i        : bin under examination (0 starts a new scan)
//   query_digit_i     : digit whose bin is reported on query_count_o
//   best_digit_o      : running/final argmax digit
//   best_count_o      : bin value of best_digit_o
//   query_count_o     : current bin value of query_digit_i
// ----------------------------------------------------------------------------
module digit_vote_hist
    import lenet_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk24,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          push_i,
    input  digit_t        push_digit_i,
    input  logic          evict_i,
    input  digit_t        evict_digit_i,
    input  logic          scan_en_i,
    input  digit_t        scan_idx_i,
    input  digit_t        query_digit_i,
    output digit_t        best_digit_o,
    output logic [CW-1:0] best_count_o,
    output logic [CW-1:0] query_count_o
);

    logic [CW-1:0] bin_q [NUM_CLASSES];
    logic [CW-1:0] bin_d [NUM_CLASSES];
    digit_t        best_digit_q;
    logic [CW-1:0] best_cnt_q;
    logic [CW-1:0] scan_bin_s;

    // Next bin values: +1 for the new digit, -1 for the evicted one; equal
    // new/evicted digits cancel, so a bin can never pass DEPTH.
    always_comb begin
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (push_i && (push_digit_i == digit_t'(k)) &&
                !(evict_i && (evict_digit_i == digit_t'(k)))) begin
                bin_d[k] = bin_q[k] + CW'(1);
            end else if (push_i && evict_i && (evict_digit_i == digit_t'(k)) &&
                         (push_digit_i != digit_t'(k))) begin
                bin_d[k] = bin_q[k] - CW'(1);
            end else begin
                bin_d[k] = bin_q[k];
            end
        end
    end

    // Bin reads guarded against the unused codes 10..15.
    always_comb begin
        if (scan_idx_i < digit_t'(NUM_CLASSES)) begin
            scan_bin_s = bin_q[scan_idx_i];
        end else begin
            scan_bin_s = {CW{1'b0}};
        end
        if (query_digit_i < digit_t'(NUM_CLASSES)) begin
            query_count_o = bin_q[query_digit_i];
        end else begin
            query_count_o = {CW{1'b0}};
        end
    end

    // Bin storage and argmax: bin 0 seeds the scan, later bins replace the
    // best only when strictly larger so ties stay with the lowest digit.
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                bin_q[k] <= {CW{1'b0}};
            end
            best_digit_q <= digit_t'(0);
            best_cnt_q   <= {CW{1'b0}};
        end else if (clear_i) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                bin_q[k] <= {CW{1'b0}};
            end
            best_digit_q <= digit_t'(0);
            best_cnt_q   <= {CW{1'b0}};
        end else begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                bin_q[k] <= bin_d[k];
            end
            if (scan_en_i && ((scan_idx_i == digit_t'(0)) || (scan_bin_s > best_cnt_q))) begin
                best_digit_q <= scan_idx_i;
                best_cnt_q   <= scan_bin_s;
            end
        end
    end

    assign best_digit_o = best_digit_q;
    assign best_count_o = best_cnt_q;

endmodule

// File: rtl/digit_vote.sv
// ----------------------------------------------------------------------------
// digit_vote
// Majority vote over the last DEPTH LeNet classifications.
//   clk24       : clock
//   rst_n       : asynchronous active-low reset
//   lenet_digit : classifier digit, taken on a lenet_ready rising edge
//   lenet_ready : classifier ready level
//   clear       : synchronous flush of history, pending result and outputs
//   vote_digit  : majority digit
//   vote_count  : occurrences of vote_digit in the window
//   vote_valid  : vote_count >= MIN_VOTES
//   busy        : update/scan/publish in progress
//   overrun     : sticky, a pending result was overwritten
// Build option: DIGIT_VOTE_HYST_EN -- the published digit only changes when
// the new winner strictly outnumbers the currently published digit.
// ----------------------------------------------------------------------------
module digit_vote
    import lenet_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int MIN_VOTES = 5,
    localparam int CW       = $clog2(DEPTH + 1),
    localparam int PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk24,
    input  logic          rst_n,
    input  logic [3:0]    lenet_digit,
    input  logic          lenet_ready,
    input  logic          clear,
    output logic [3:0]    vote_digit,
    output logic [CW-1:0] vote_count,
    output logic          vote_valid,
    output logic          busy,
    output logic          overrun
);

    vote_state_t   state_q;
    logic          ready_q;
    digit_t        scan_idx_q;
    digit_t        hist_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] fill_q;
    logic          pend_v_q;
    digit_t        pend_digit_q;
    digit_t        job_digit_q;
    digit_t        vote_digit_q;
    logic [CW-1:0] vote_count_q;
    logic          vote_valid_q;
    logic          busy_q;
    logic          overrun_q;

    logic          edge_s;
    logic          full_s;
    digit_t        best_digit_s;
    logic [CW-1:0] best_cnt_s;
    logic [CW-1:0] cur_cnt_s;

    // Accepted result: rising edge of ready carrying a real class code.
    always_comb begin
        edge_s = lenet_ready && !ready_q && digit_ok(lenet_digit);
        full_s = (fill_q == CW'(DEPTH));
    end

    digit_vote_hist #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_hist (
        .clk24         (clk24),
        .rst_n         (rst_n),
        .clear_i       (clear),
        .push_i        (state_q == UPDATE),
        .push_digit_i  (job_digit_q),
        .evict_i       (full_s),
        .evict_digit_i (hist_q[wr_ptr_q]),
        .scan_en_i     (state_q == SCAN),
        .scan_idx_i    (scan_idx_q),
        .query_digit_i (vote_digit_q),
        .best_digit_o  (best_digit_s),
        .best_count_o  (best_cnt_s),
        .query_count_o (cur_cnt_s)
    );

    // Controller: edge capture, pending slot, history ring and published outputs.
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ready_q      <= 1'b0;
            scan_idx_q   <= digit_t'(0);
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= digit_t'(0);
            end
            wr_ptr_q     <= {PW{1'b0}};
            fill_q       <= {CW{1'b0}};
            pend_v_q     <= 1'b0;
            pend_digit_q <= digit_t'(0);
            job_digit_q  <= digit_t'(0);
            vote_digit_q <= digit_t'(0);
            vote_count_q <= {CW{1'b0}};
            vote_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            // Ready is tracked even during clear so a held level is not
            // re-seen as a fresh edge afterwards.
            ready_q <= lenet_ready;
            if (clear) begin
                state_q      <= IDLE;
                scan_idx_q   <= digit_t'(0);
                for (int i = 0; i < DEPTH; i++) begin
                    hist_q[i] <= digit_t'(0);
                end
                wr_ptr_q     <= {PW{1'b0}};
                fill_q       <= {CW{1'b0}};
                pend_v_q     <= 1'b0;
                pend_digit_q <= digit_t'(0);
                job_digit_q  <= digit_t'(0);
                vote_digit_q <= digit_t'(0);
                vote_count_q <= {CW{1'b0}};
                vote_valid_q <= 1'b0;
                busy_q       <= 1'b0;
                overrun_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        // A waiting result goes first; a simultaneous new one
                        // takes over the slot it frees.
                        if (pend_v_q) begin
                            job_digit_q <= pend_digit_q;
                            state_q     <= UPDATE;
                            busy_q      <= 1'b1;
                            pend_v_q    <= edge_s;
                            if (edge_s) begin
                                pend_digit_q <= lenet_digit;
                            end
                        end else if (edge_s) begin
                            job_digit_q <= lenet_digit;
                            state_q     <= UPDATE;
                            busy_q      <= 1'b1;
                        end
                    end
                    UPDATE: begin
                        hist_q[wr_ptr_q] <= job_digit_q;
                        if (wr_ptr_q == PW'(DEPTH - 1)) begin
                            wr_ptr_q <= {PW{1'b0}};
                        end else begin
                            wr_ptr_q <= wr_ptr_q + PW'(1);
                        end
                        if (!full_s) begin
                            fill_q <= fill_q + CW'(1);
                        end
                        scan_idx_q <= digit_t'(0);
                        state_q    <= SCAN;
                    end
                    SCAN: begin
                        if (scan_idx_q == digit_t'(SCAN_LAST)) begin
                            state_q <= PUBLISH;
                        end else begin
                            scan_idx_q <= scan_idx_q + digit_t'(1);
                        end
                    end
                    PUBLISH: begin
`ifdef DIGIT_VOTE_HYST_EN
                        if (best_cnt_s > cur_cnt_s) begin
                            vote_digit_q <= best_digit_s;
                            vote_count_q <= best_cnt_s;
                            vote_valid_q <= (best_cnt_s >= CW'(MIN_VOTES));
                        end else begin
                            vote_count_q <= cur_cnt_s;
                            vote_valid_q <= (cur_cnt_s >= CW'(MIN_VOTES));
                        end
`else
                        vote_digit_q <= best_digit_s;
                        vote_count_q <= best_cnt_s;
                        vote_valid_q <= (best_cnt_s >= CW'(MIN_VOTES));
`endif
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
                // Arrivals while working land in the 1-deep pending slot.
                if ((state_q != IDLE) && edge_s) begin
                    pend_v_q     <= 1'b1;
                    pend_digit_q <= lenet_digit;
                    if (pend_v_q) begin
                        overrun_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign vote_digit = vote_digit_q;
    assign vote_count = vote_count_q;
    assign vote_valid = vote_valid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_digit_vote.sv
module tb_digit_vote;

    localparam int DEPTH     = 8;
    localparam int MIN_VOTES = 5;
    localparam int CW        = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic [3:0]    lenet_digit;
    logic          lenet_ready;
    logic          clear;
    logic [3:0]    vote_digit;
    logic [CW-1:0] vote_count;
    logic          vote_valid;
    logic          busy;
    logic          overrun;

    int n_cmp = 0;
    int n_err = 0;

    digit_vote #(.DEPTH(DEPTH), .MIN_VOTES(MIN_VOTES)) u_dut (
        .clk24       (clk),
        .rst_n       (rst_n),
        .lenet_digit (lenet_digit),
        .lenet_ready (lenet_ready),
        .clear       (clear),
        .vote_digit  (vote_digit),
        .vote_count  (vote_count),
        .vote_valid  (vote_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int d);
        lenet_digit = 4'(d);
        lenet_ready = 1'b1;
        step();
        lenet_ready = 1'b0;
    endtask

    task automatic push_wait(input int d);
        pulse(d);
        repeat (14) step();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic chk_out(input string nm, input int d, input int c, input int v);
        chk({nm, ".digit"}, 32'(vote_digit), d);
        chk({nm, ".count"}, 32'(vote_count), c);
        chk({nm, ".valid"}, 32'(vote_valid), v);
    endtask

    // ---------------- behavioural reference model ----------------
    int m_win[$];
    int m_ph, m_pd, m_job, m_vd, m_vc;
    bit m_pv, m_prev, m_vv, m_ov;

    function automatic void m_clear();
        m_win.delete();
        m_ph = 0; m_pv = 1'b0; m_pd = 0; m_job = 0;
        m_vd = 0; m_vc = 0; m_vv = 1'b0; m_ov = 1'b0;
    endfunction

    function automatic void m_publish(input int d);
        int cnt[10];
        int w, wc;
        if (m_win.size() == DEPTH) void'(m_win.pop_front());
        m_win.push_back(d);
        for (int k = 0; k < 10; k++) cnt[k] = 0;
        foreach (m_win[i]) cnt[m_win[i]]++;
        w = 0;
        wc = cnt[0];
        for (int k = 1; k < 10; k++) begin
            if (cnt[k] > wc) begin
                w = k;
                wc = cnt[k];
            end
        end
`ifdef DIGIT_VOTE_HYST_EN
        if (wc > cnt[m_vd]) begin
            m_vd = w;
            m_vc = wc;
        end else begin
            m_vc = cnt[m_vd];
        end
`else
        m_vd = w;
        m_vc = wc;
`endif
        m_vv = (m_vc >= MIN_VOTES);
    endfunction

    // One clock of the model: a job occupies 12 cycles from its start edge
    // to the publish edge; arrivals during a job wait in a single slot.
    function automatic void m_step(input bit rdy, input int dig, input bit clr);
        bit e;
        e = rdy && !m_prev && (dig <= 9);
        m_prev = rdy;
        if (clr) begin
            m_clear();
        end else if (m_ph == 0) begin
            if (m_pv) begin
                m_job = m_pd;
                m_ph = 12;
                m_pv = e;
                if (e) m_pd = dig;
            end else if (e) begin
                m_job = dig;
                m_ph = 12;
            end
        end else begin
            if (e) begin
                if (m_pv) m_ov = 1'b1;
                m_pv = 1'b1;
                m_pd = dig;
            end
            m_ph--;
            if (m_ph == 0) m_publish(m_job);
        end
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        bit clr;
        int dig;
        int e_dig;
        int e_cnt;
        int e_val;
    } vec_t;

    vec_t tbl [0:22];

    initial begin
        int maxbin;
        rst_n = 1'b0;
        clear = 1'b0;
        lenet_ready = 1'b0;
        lenet_digit = 4'd0;

        tbl[0]  = '{1'b0, 3, 3, 1, 0};
        tbl[1]  = '{1'b0, 3, 3, 2, 0};
        tbl[2]  = '{1'b0, 3, 3, 3, 0};
        tbl[3]  = '{1'b0, 3, 3, 4, 0};
        tbl[4]  = '{1'b0, 3, 3, 5, 1};
        tbl[5]  = '{1'b0, 7, 3, 5, 1};
        tbl[6]  = '{1'b0, 7, 3, 5, 1};
        tbl[7]  = '{1'b0, 7, 3, 5, 1};
        tbl[8]  = '{1'b0, 7, 3, 4, 0};
        tbl[9]  = '{1'b0, 7, 7, 5, 1};
        tbl[10] = '{1'b0, 7, 7, 6, 1};
        tbl[11] = '{1'b0, 7, 7, 7, 1};
        tbl[12] = '{1'b0, 7, 7, 8, 1};
        tbl[13] = '{1'b0, 2, 7, 7, 1};
        tbl[14] = '{1'b0, 2, 7, 6, 1};
        tbl[15] = '{1'b1, 1, 1, 1, 0};
        tbl[16] = '{1'b0, 1, 1, 2, 0};
        tbl[17] = '{1'b0, 1, 1, 3, 0};
        tbl[18] = '{1'b0, 1, 1, 4, 0};
        tbl[19] = '{1'b0, 6, 1, 4, 0};
        tbl[20] = '{1'b0, 6, 1, 4, 0};
        tbl[21] = '{1'b0, 6, 1, 4, 0};
        tbl[22] = '{1'b0, 6, 1, 4, 0};

        // Reset state
        repeat (2) step();
        chk_out("reset", 0, 0, 0);
        chk("reset.busy", 32'(busy), 0);
        chk("reset.overrun", 32'(overrun), 0);
        rst_n = 1'b1;
        step();

        for (int r = 0; r < 23; r++) begin
            if (tbl[r].clr) do_clear();
            push_wait(tbl[r].dig);
            chk_out($sformatf("tbl%0d", r), tbl[r].e_dig, tbl[r].e_cnt, tbl[r].e_val);
            if (r == 14) begin
                chk("bin2", 32'(u_dut.u_hist.bin_q[2]), 2);
                maxbin = 0;
                for (int k = 0; k < 10; k++)
                    if (int'(u_dut.u_hist.bin_q[k]) > maxbin) maxbin = int'(u_dut.u_hist.bin_q[k]);
                chk("maxbin_le_depth", 32'(maxbin <= DEPTH), 1);
            end
        end

        // Reset in SCAN cycle 5, then the window must be empty
        pulse(6);
        repeat (5) step();
        chk("pre_rst.busy", 32'(busy), 1);
        rst_n = 1'b0;
        #2;
        chk_out("mid_rst", 0, 0, 0);
        chk("mid_rst.busy", 32'(busy), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("after_rst.busy", 32'(busy), 0);
        push_wait(2);
        chk_out("after_rst.push", 2, 1, 0);

        // Publish latency: outputs change exactly 12 cycles after the edge
        do_clear();
        pulse(5);
        chk("lat.busy_t0", 32'(busy), 1);
        repeat (11) step();
        chk("lat.digit_t11", 32'(vote_digit), 0);
        chk("lat.busy_t11", 32'(busy), 1);
        step();
        chk_out("lat_t12", 5, 1, 0);
        step();
        chk("lat.busy_t13", 32'(busy), 0);

        // Three arrivals during one SCAN: newest wins, overrun flagged
        do_clear();
        pulse(9);
        step();
        pulse(1);
        repeat (3) step();
        chk("ovr.first_pend", 32'(overrun), 0);
        pulse(2);
        repeat (3) step();
        pulse(8);
        repeat (3) step();
        repeat (30) step();
        chk_out("ovr", 8, 1, 0);
        chk("ovr.flag", 32'(overrun), 1);

        // Out-of-range digit is ignored
        pulse(12);
        chk("bad.busy0", 32'(busy), 0);
        repeat (3) step();
        chk("bad.busy3", 32'(busy), 0);
        chk_out("bad", 8, 1, 0);
        push_wait(8);
        chk_out("bad.after", 8, 2, 0);

        // clear coincident with an edge: clear wins, result dropped
        clear = 1'b1;
        pulse(5);
        clear = 1'b0;
        chk_out("clr_edge", 0, 0, 0);
        chk("clr_edge.overrun", 32'(overrun), 0);
        chk("clr_edge.busy", 32'(busy), 0);
        repeat (14) step();
        chk_out("clr_edge.late", 0, 0, 0);
        chk("clr_edge.busy_late", 32'(busy), 0);

        // Randomised run against the reference model
        rst_n = 1'b0;
        lenet_ready = 1'b0;
        clear = 1'b0;
        step();
        rst_n = 1'b1;
        m_clear();
        m_prev = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 4) == 0) lenet_ready = ~lenet_ready;
            lenet_digit = 4'($urandom_range(0, 11));
            clear = ($urandom_range(0, 299) == 0);
            @(posedge clk);
            m_step(lenet_ready, int'(lenet_digit), clear);
            #1;
            chk("rnd.digit", 32'(vote_digit), m_vd);
            chk("rnd.count", 32'(vote_count), m_vc);
            chk("rnd.valid", 32'(vote_valid), int'(m_vv));
            chk("rnd.busy", 32'(busy), int'(m_ph != 0));
            chk("rnd.overrun", 32'(overrun), int'(m_ov));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
